seq_detect_stream_ctrl: RTL and testbench
=========================================

// Module: seq_detect_stream_ctrl
// PURPOSE
//  Feeds a Mealy serial pattern detector from a parallel word stream (serialized MSB-first) and counts detections per frame.
//  Holds the detector's run-time configuration: target pattern and overlap mode.
//  Sits between a word producer (valid/ready) and status logic that reads per-frame match counts.
// PARAMETERS
//  WORD_W   8        input word width; serial bits per word
//  PAT_W    4        detected pattern length, 2..WORD_W
//  CNT_W    8        match counter width (saturating)
//  PAT_RST  4'b1011  pattern value loaded on reset (PAT_W bits)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high; clears all state
//  cfg_we       in   1       load cfg_pattern/cfg_overlap (honoured in IDLE only)
//  cfg_pattern  in   PAT_W   target pattern; MSB is the earliest bit
//  cfg_overlap  in   1       1 = overlapping matches; 0 = history cleared after a match
//  in_valid     in   1       word available
//  in_data      in   WORD_W  word, serialized MSB-first
//  in_last      in   1       word is the last of its frame
//  in_ready     out  1       word accepted on clk edge when in_valid&in_ready
//  match_pulse  out  1       1-cycle pulse per detection (registered)
//  match_count  out  CNT_W   detections in current/last frame
//  overflow     out  1       sticky: count saturated this frame
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse: frame finished, match_count final
// BEHAVIOUR
//  Reset values: in_ready=1, all other outputs 0; pattern=PAT_RST, overlap=1, state IDLE, history empty, frame_start=1.
//  FSM: IDLE -> SHIFT on accept; SHIFT runs WORD_W cycles -> IDLE (in_last=0) or DONE (in_last=1); DONE -> IDLE after 1 cycle.
//  in_ready=1 only in IDLE; one word per WORD_W+1 cycles max. Word, in_last captured at accept edge E0.
//  Accept with frame_start=1: match_count, overflow, history cleared at E0; frame_start drops. Set again on entering DONE.
//  SHIFT: bit i (i=1..WORD_W) presented to core in cycle after E(i-1), consumed at edge Ei.
//  Core is Mealy: match = ({hist[PAT_W-2:0],bit}==pattern) && hist_len>=PAT_W-1, combinational from bit and state.
//  Registered at Ei: match_pulse<=match; match_count+=match (saturates at 2^CNT_W-1; a match at saturation sets overflow).
//  History shifts in each bit; persists across words within a frame (cross-word matches count).
//  cfg_overlap=0: on match, history and hist_len cleared at Ei instead of shifting.
//  done pulses in cycle after E_WORD_W of the last word, coincident with that bit's match_pulse; count already includes it.
//  match_count/overflow hold after done until next frame's first accept.
//  cfg_we outside IDLE ignored (no queuing); in IDLE it takes effect from the next accepted word.
//  in_valid is ignored while in_ready=0; in_data need not be held once accepted.
//  Reset mid-frame: immediate return to reset values; partial count discarded; no done.
// STRUCTURE
//  Package seq_detect_pkg: state encoding (IDLE, SHIFT, DONE), default PAT_RST, PAT_W/WORD_W defaults.
//  Sub-module seq_detect_core: programmable Mealy detector (hist, hist_len, overlap, bit_in, bit_en, clear -> match).
//  Top holds FSM, shift register, bit counter ($clog2(WORD_W)), match counter, cfg registers.
// TESTING
//  T1 pattern 1011 overlap=1, one word 8'hB6 in_last=1 -> pulses after bits 4 and 7; done with match_count=2.
//  T2 same, overlap=0 -> single pulse after bit 4; match_count=1, overflow=0.
//  T3 words 8'h05 then 8'h80 (last), pattern 1011 -> 1 match, on bit 1 of word 2; count=1.
//  T4 pattern 1111 overlap=1, 33 words 8'hFF (last on 33rd) -> 5+32*8=261 -> count=255, overflow=1.
//  T5 reset at bit 3 of a word -> outputs at reset values at once; next frame counts from 0; pattern=1011.
//  T6 cfg_we with pattern 0110 during SHIFT -> ignored; same in IDLE -> 8'h66 gives count=2.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared state encoding and default configuration for the serial pattern
// detector stream controller.
package seq_detect_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_detect_core.sv
// Programmable Mealy pattern detector: match is combinational from the
// incoming bit and the stored history of previous bits.
module seq_detect_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clear,
  output logic             match
);

  localparam int LEN_W = $clog2(PAT_W);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] window;

  always_comb begin
    window = {hist_q, bit_in};
    match  = bit_en && (window == pattern) && (len_q == LEN_FULL);
    hist_d = hist_q;
    len_d  = len_q;
    if (clear) begin
      hist_d = '0;
      len_d  = '0;
    end else if (bit_en) begin
      // Non-overlapping mode restarts from an empty history after a hit
      if (match && !overlap) begin
        hist_d = '0;
        len_d  = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        if (len_q != LEN_FULL) len_d = len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      len_q  <= '0;
    end else begin
      hist_q <= hist_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/seq_detect_stream_ctrl.sv
// Serializes accepted words MSB-first into the Mealy detector and keeps a
// saturating per-frame match count with a done pulse at frame end.
module seq_detect_stream_ctrl
  import seq_detect_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              pulse_q, pulse_d;
  logic              frame_start_q, frame_start_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;

  logic accept, bit_en, core_clear, match;

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign bit_en     = (state_q == ST_SHIFT);
  assign core_clear = accept && frame_start_q;

  seq_detect_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .pattern (pat_q),
    .overlap (ovl_q),
    .bit_in  (shreg_q[WORD_W-1]),
    .bit_en  (bit_en),
    .clear   (core_clear),
    .match   (match)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    last_d        = last_q;
    bit_cnt_d     = bit_cnt_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    pulse_d       = 1'b0;
    frame_start_d = frame_start_q;
    pat_d         = pat_q;
    ovl_d         = ovl_q;
    in_ready      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (cfg_we) begin
          pat_d = cfg_pattern;
          ovl_d = cfg_overlap;
        end
        if (in_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = in_data;
          last_d    = in_last;
          bit_cnt_d = '0;
          if (frame_start_q) begin
            cnt_d         = '0;
            ovf_d         = 1'b0;
            frame_start_d = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        pulse_d   = match;
        if (match) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
        if (bit_cnt_q == LAST_BIT) begin
          if (last_q) begin
            state_d       = ST_DONE;
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      last_q        <= 1'b0;
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      pulse_q       <= 1'b0;
      frame_start_q <= 1'b1;
      pat_q         <= PAT_RST;
      ovl_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      pulse_q       <= pulse_d;
      frame_start_q <= frame_start_d;
      pat_q         <= pat_d;
      ovl_q         <= ovl_d;
    end
  end

  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// Directed bench for seq_detect_stream_ctrl: hand-computed pulse positions,
// frame counts, saturation, mid-frame reset and configuration gating.
module tb_seq_detect_stream_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              overflow;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  logic [WORD_W:0] w_mask;
  logic            w_done;
  logic            w_busy;

  seq_detect_stream_ctrl #(
    .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RST(4'b1011)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_pulse"},    32'(match_pulse), 32'd0);
    check_eq({tag, "_count"},    32'(match_count), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_busy"},     32'(busy), 32'd0);
    check_eq({tag, "_done"},     32'(done), 32'd0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      check_eq("ready_wait", 32'(in_ready), 32'd1);
      ok = 1'b0;
    end
  endtask

  task automatic set_cfg(input logic [PAT_W-1:0] p, input logic ov);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_overlap = ov;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Sends one word; w_mask bit i is set if match_pulse was seen after bit i.
  task automatic send_word(input logic [WORD_W-1:0] d, input logic last,
                           input int cfg_mid, input int abort_at);
    bit ok;
    w_mask = '0;
    w_done = 1'b0;
    w_busy = 1'b0;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_last  = ~last;
    for (int i = 1; i <= WORD_W; i++) begin
      @(posedge clk);
      #1;
      w_mask[i] = match_pulse;
      if (i == 1) w_busy = busy;
      if (i == WORD_W) w_done = done;
      if (i == cfg_mid) begin
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_overlap = 1'b0;
      end else begin
        cfg_we = 1'b0;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        $display("word %02h last=%0d aborted by reset after bit %0d", d, last, i);
        return;
      end
    end
    $display("word %02h last=%0d pulses=%03h count=%0d overflow=%0d done=%0d",
             d, last, w_mask, match_count, overflow, w_done);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // T1: 1011 overlapping on B6 -> hits after bits 4 and 7
    send_word(8'hB6, 1'b1, 0, 0);
    check_eq("t1_mask",  32'(w_mask), 32'h090);
    check_eq("t1_done",  32'(w_done), 32'd1);
    check_eq("t1_count", 32'(match_count), 32'd2);
    check_eq("t1_busy",  32'(w_busy), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t1_count_hold", 32'(match_count), 32'd2);
    check_eq("t1_ready_idle", 32'(in_ready), 32'd1);

    // T2: non-overlapping mode
    set_cfg(4'b1011, 1'b0);
    send_word(8'hB6, 1'b1, 0, 0);
    check_eq("t2_mask",     32'(w_mask), 32'h010);
    check_eq("t2_count",    32'(match_count), 32'd1);
    check_eq("t2_overflow", 32'(overflow), 32'd0);

    // T3: match straddling a word boundary
    set_cfg(4'b1011, 1'b1);
    send_word(8'h05, 1'b0, 0, 0);
    check_eq("t3_w1_mask", 32'(w_mask), 32'h000);
    check_eq("t3_w1_done", 32'(w_done), 32'd0);
    send_word(8'h80, 1'b1, 0, 0);
    check_eq("t3_w2_mask", 32'(w_mask), 32'h002);
    check_eq("t3_count",   32'(match_count), 32'd1);
    check_eq("t3_done",    32'(w_done), 32'd1);

    // T4: 261 hits saturate the 8-bit counter
    set_cfg(4'b1111, 1'b1);
    for (int w = 1; w <= 33; w++) send_word(8'hFF, (w == 33), 0, 0);
    check_eq("t4_last_mask", 32'(w_mask), 32'h1FE);
    check_eq("t4_count",     32'(match_count), 32'd255);
    check_eq("t4_overflow",  32'(overflow), 32'd1);
    check_eq("t4_done",      32'(w_done), 32'd1);

    // T5: reset in the middle of a word restores default config
    set_cfg(4'b0110, 1'b0);
    send_word(8'hB6, 1'b1, 0, 2);
    send_word(8'hB6, 1'b1, 0, 0);
    check_eq("t5_mask",     32'(w_mask), 32'h090);
    check_eq("t5_count",    32'(match_count), 32'd2);
    check_eq("t5_overflow", 32'(overflow), 32'd0);

    // T6: config write while shifting is dropped; in IDLE it sticks
    send_word(8'h66, 1'b1, 3, 0);
    check_eq("t6_busy_cfg_mask",  32'(w_mask), 32'h000);
    check_eq("t6_busy_cfg_count", 32'(match_count), 32'd0);
    set_cfg(4'b0110, 1'b1);
    send_word(8'h66, 1'b1, 0, 0);
    check_eq("t6_mask",  32'(w_mask), 32'h110);
    check_eq("t6_count", 32'(match_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
